i2c_byte_master: RTL and testbench

Single-byte I2C master engine between the APB register block and the open-drain SDA/SCL pads of the I2C peripheral. It takes the start/reset/interrupt-enable controls and the peripheral address/data latched by the APB slave, runs one complete I2C transaction (START, address+R/W, one data byte, STOP), and returns read data, completion and acknowledge status for software to read back over APB.

---
 rtl/i2c_byte_master.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, address+R/W, one data byte (write or read), STOP.
// Each bit-time is split into four quarters of CLK_DIV clocks. Pad controls
// are decoded from the registered state and counters.
module i2c_byte_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startbit,
    input  logic       resetbit,
    input  logic       it_enable,
    input  logic       rw,
    input  logic [6:0] per_addr,
    input  logic [7:0] per_data,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       ready,
    output logic       ack_err,
    output logic       irq,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP, DONE
    } state_t;

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLK_DIV - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [1:0]     qtr_q, qtr_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     addr_q, addr_d;      // {per_addr, rw} as sent on the wire
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rx_q, rx_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           ack_err_q, ack_err_d;
    logic           done_q, done_d;

    logic qtr_end, bit_end, sample_pt, last_bit;

    assign qtr_end   = (cyc_q == CYC_LAST);
    assign bit_end   = qtr_end && (qtr_q == 2'd3);
    assign sample_pt = qtr_end && (qtr_q == 2'd1);
    assign last_bit  = (bit_q == 3'd7);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    // Next-state, datapath updates and quarter/bit counters.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = done_q;
        cyc_d     = cyc_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;

        case (state_q)
            IDLE: begin
                if (startbit) begin
                    addr_d    = {per_addr, rw};
                    wdata_d   = per_data;
                    ack_err_d = 1'b0;
                    done_d    = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) state_d = ADDR;
            end
            ADDR: begin
                if (bit_end && last_bit) state_d = ADDR_ACK;
            end
            ADDR_ACK: begin
                // ack_err was cleared at start, so by bit_end it holds this ACK.
                if (sample_pt && sda_i) ack_err_d = 1'b1;
                if (bit_end) begin
                    if (ack_err_q)    state_d = STOP;
                    else if (addr_q[0]) state_d = RDATA;
                    else              state_d = WDATA;
                end
            end
            WDATA: begin
                if (bit_end && last_bit) state_d = WACK;
            end
            WACK: begin
                if (sample_pt && sda_i) ack_err_d = 1'b1;
                if (bit_end) state_d = STOP;
            end
            RDATA: begin
                if (sample_pt) rx_d = {rx_q[6:0], sda_i};
                if (bit_end && last_bit) state_d = RNACK;
            end
            RNACK: begin
                if (bit_end) begin
                    rdata_d = rx_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                // done_pending rises together with DONE so irq lines up with ready.
                if (bit_end) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Soft abort wins over everything, including a same-cycle startbit.
        if (resetbit) begin
            state_d   = IDLE;
            ack_err_d = 1'b0;
            done_d    = 1'b0;
            rdata_d   = '0;
        end

        // Counters restart on every state entry; idle states keep them at zero.
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
            cyc_d = '0;
            qtr_d = '0;
            bit_d = '0;
        end else if (qtr_end) begin
            cyc_d = '0;
            qtr_d = qtr_q + 2'd1;
            if (bit_end) bit_d = bit_q + 3'd1;
        end else begin
            cyc_d = cyc_q + CW'(1);
        end
    end

    // Pad controls and status decoded from the current state and quarter.
    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        case (state_q)
            START: begin
                sda_o = (qtr_q < 2'd2);
                scl_o = (qtr_q != 2'd3);
            end
            ADDR: begin
                scl_o = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_o = addr_q[3'd7 - bit_q];
            end
            WDATA: begin
                scl_o = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_o = wdata_q[3'd7 - bit_q];
            end
            ADDR_ACK, WACK, RDATA, RNACK: begin
                scl_o = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_o = 1'b1;
            end
            STOP: begin
                sda_o = (qtr_q >= 2'd2);
                scl_o = (qtr_q != 2'd0);
            end
            default: begin
                scl_o = 1'b1;
                sda_o = 1'b1;
            end
        endcase
    end

    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign ready   = (state_q == DONE);
    assign rdata   = rdata_q;
    assign ack_err = ack_err_q;
    assign irq     = it_enable & done_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Randomized bench for i2c_byte_master: a behavioural I2C slave decodes the
// bus on SCL edges, and a transaction-level model predicts status and timing.
module tb_i2c_byte_master;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       startbit, resetbit, it_enable, rw;
    logic [6:0] per_addr;
    logic [7:0] per_data;
    logic [7:0] rdata;
    logic       busy, ready, ack_err, irq, scl_o, sda_o, sda_i;

    // Behavioural slave state (written only by the slave process).
    logic       slave_sda = 1'b1;
    logic       s_scl_prev = 1'b1;
    logic       s_sda_prev = 1'b1;
    int         bitcnt = 0;
    int         byte_idx = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       is_read = 1'b0;
    logic       ack_val = 1'b0;
    int         stop_cnt = 0;
    logic [7:0] dec_q[$];
    logic       ack_q[$];

    // Slave configuration, set by the stimulus before each transaction.
    logic       slv_nack_addr = 1'b0;
    logic       slv_nack_data = 1'b0;
    logic [7:0] slv_tx = 8'h00;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] rdata_model = 8'h00;
    int         txn_no = 0;

    assign sda_i = sda_o & slave_sda;

    i2c_byte_master #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .startbit(startbit), .resetbit(resetbit),
        .it_enable(it_enable), .rw(rw), .per_addr(per_addr), .per_data(per_data),
        .rdata(rdata), .busy(busy), .ready(ready), .ack_err(ack_err), .irq(irq),
        .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // I2C slave: START/STOP detection, bit decode on SCL rise, drive on SCL fall.
    always @(negedge clk) begin
        logic sda_now;
        sda_now = sda_i;
        if (s_scl_prev && scl_o && s_sda_prev && !sda_now) begin
            bitcnt = 0; byte_idx = 0; rx_byte = 8'h00; is_read = 1'b0; slave_sda = 1'b1;
        end else if (s_scl_prev && scl_o && !s_sda_prev && sda_now) begin
            stop_cnt++;
        end else if (!s_scl_prev && scl_o) begin
            if (bitcnt < 8) rx_byte = {rx_byte[6:0], sda_now};
            else ack_val = sda_now;
            bitcnt++;
            if (bitcnt == 8) begin
                dec_q.push_back(rx_byte);
                if (byte_idx == 0) is_read = rx_byte[0];
            end
            if (bitcnt == 9) ack_q.push_back(ack_val);
        end else if (s_scl_prev && !scl_o) begin
            if (bitcnt == 8) begin
                if (byte_idx == 0)  slave_sda = slv_nack_addr;
                else if (!is_read)  slave_sda = slv_nack_data;
                else                slave_sda = 1'b1;
            end else if (bitcnt == 9) begin
                bitcnt = 0;
                byte_idx++;
                rx_byte = 8'h00;
                if (is_read && byte_idx == 1 && !slv_nack_addr) slave_sda = slv_tx[7];
                else slave_sda = 1'b1;
            end else if (bitcnt >= 1 && is_read && byte_idx == 1 && !slv_nack_addr) begin
                slave_sda = slv_tx[7 - bitcnt];
            end
        end
        s_scl_prev = scl_o;
        s_sda_prev = sda_now;
    end

    // One full transaction, checked against the transaction-level model.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input logic [7:0] sb, input logic na, input logic nd,
                           input logic ien, input logic ghost);
        int base_d, base_a, st0, cnt, bits, exp_lat;
        logic seen;
        logic exp_err;
        slv_nack_addr = na; slv_nack_data = nd; slv_tx = sb;
        base_d = dec_q.size(); base_a = ack_q.size(); st0 = stop_cnt;
        bits    = 1 + 9 + (na ? 0 : 9) + 1;
        exp_lat = bits * 4 * D + 1;
        exp_err = na | (!r & nd);
        @(negedge clk);
        it_enable = ien; per_addr = a; rw = r; per_data = d; startbit = 1'b1;
        @(negedge clk);
        startbit = 1'b0; cnt = 1;
        chk("busy_start", busy, 1);
        chk("irq_cleared", irq, 0);
        seen = 1'b0;
        while (!seen && cnt < 3000) begin
            if (ready) seen = 1'b1;
            else begin
                @(negedge clk);
                cnt++;
                if (ghost && cnt == 150) begin startbit = 1'b1; per_data = ~d; end
                else startbit = 1'b0;
            end
        end
        chk("ready_seen", seen, 1);
        if (!na && r) rdata_model = sb;
        if (seen) begin
            chk("latency", cnt, exp_lat);
            chk("busy_done", busy, 0);
            chk("ack_err", ack_err, exp_err);
            chk("rdata", rdata, rdata_model);
            chk("irq_done", irq, ien);
        end
        @(negedge clk);
        chk("ready_pulse", ready, 0);
        chk("irq_hold", irq, ien);
        chk("scl_idle", scl_o, 1);
        chk("sda_idle", sda_o, 1);
        chk("n_bytes", dec_q.size() - base_d, na ? 1 : 2);
        if (dec_q.size() > base_d) chk("addr_byte", dec_q[base_d], {a, r});
        if (!na && dec_q.size() > base_d + 1) chk("data_byte", dec_q[base_d + 1], r ? sb : d);
        if (ack_q.size() > base_a) chk("addr_ack", ack_q[base_a], na);
        if (!na && ack_q.size() > base_a + 1) chk("ninth_bit", ack_q[base_a + 1], r ? 1'b1 : nd);
        chk("stop_seen", stop_cnt - st0, 1);
        txn_no++;
        $display("txn %0d: addr=%02h rw=%0d data=%02h slv=%02h nack=%0d/%0d lat=%0d ack_err=%0d rdata=%02h",
                 txn_no, a, r, d, sb, na, nd, cnt, ack_err, rdata);
    endtask

    // Start a write, abort it during the 4th data bit with resetbit or rst.
    task automatic abort_txn(input logic use_rst);
        int cnt, rdy;
        slv_nack_addr = 1'b0; slv_nack_data = 1'b0;
        @(negedge clk);
        it_enable = 1'b1; per_addr = 7'($urandom); rw = 1'b0; per_data = 8'($urandom);
        startbit = 1'b1;
        @(negedge clk);
        startbit = 1'b0; cnt = 1;
        while (cnt < 213) begin @(negedge clk); cnt++; end
        chk("abort_busy_before", busy, 1);
        if (use_rst) begin
            rst = 1'b1;
            #1;
            chk("rst_scl", scl_o, 1); chk("rst_sda", sda_o, 1); chk("rst_busy", busy, 0);
            chk("rst_rdata", rdata, 0); chk("rst_irq", irq, 0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            resetbit = 1'b1;
            @(negedge clk);
            resetbit = 1'b0;
            chk("rb_scl", scl_o, 1); chk("rb_sda", sda_o, 1); chk("rb_busy", busy, 0);
            chk("rb_ready", ready, 0); chk("rb_ack_err", ack_err, 0); chk("rb_rdata", rdata, 0);
        end
        rdata_model = 8'h00;
        rdy = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (ready) rdy++; end
        chk("abort_no_ready", rdy, 0);
        txn_no++;
        $display("txn %0d: abort via %s at cycle %0d", txn_no, use_rst ? "rst" : "resetbit", cnt);
    endtask

    initial begin
        rst = 1'b1; startbit = 1'b0; resetbit = 1'b0; it_enable = 1'b0;
        rw = 1'b0; per_addr = 7'h00; per_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_scl", scl_o, 1); chk("reset_sda", sda_o, 1); chk("reset_busy", busy, 0);
        chk("reset_ready", ready, 0); chk("reset_rdata", rdata, 0);
        chk("reset_ack_err", ack_err, 0); chk("reset_irq", irq, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed cases.
        run_txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        it_enable = 1'b0;
        @(negedge clk); chk("irq_masked", irq, 0);
        it_enable = 1'b1;
        @(negedge clk); chk("irq_unmasked", irq, 1);
        run_txn(7'h50, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        run_txn(7'h50, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(7'h2B, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        abort_txn(1'b0);
        run_txn(7'h11, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        abort_txn(1'b1);

        // Randomized transactions.
        for (int i = 0; i < 10; i++) begin
            run_txn(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
